qsgmii_rx_lane_aligner: RTL



---
 rtl/qsgmii_rx_lane_aligner.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/qsgmii_rx_lane_aligner.sv
`default_nettype none
// ============================================================================
// Module   : qsgmii_rx_lane_aligner
// Purpose  : Locks onto the port-0 K28.1 column marker of a 32-bit QSGMII RX
//            lane and rotates bytes so port 0 always lands on byte 0.
// Options  : define QSGMII_ALIGN_STATS_EN to add relock/bad-word counters.
// Revision : 1.0  initial release
// ============================================================================
module qsgmii_rx_lane_aligner #(
    parameter int LOCK_COUNT     = 4,
    parameter int LOSS_THRESH    = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        rx_clk,
    input  logic        rx_rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_is_ctl,
    input  logic [3:0]  in_symbol_err,
    input  logic [3:0]  in_disparity_err,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [3:0]  out_is_ctl,
    output logic [3:0]  out_symbol_err,
    output logic [3:0]  out_disparity_err,
    output logic        locked,
    output logic [1:0]  offset
`ifdef QSGMII_ALIGN_STATS_EN
    ,
    output logic [15:0] relock_count,
    output logic [15:0] bad_word_count
`endif
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]       c_lock_cnt = LOCK_COUNT[3:0];
    localparam logic [7:0]       c_loss_thr = LOSS_THRESH[7:0];
    localparam logic [TMR_W-1:0] c_timeout  = TIMEOUT_CYCLES[TMR_W-1:0];

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_match_cnt;
    logic [7:0]       r_err_cnt;
    logic [TMR_W-1:0] r_timer;
    logic [1:0]       r_offset;
    logic             r_locked;
    logic             r_out_valid;
    logic [31:0]      r_prev_data;
    logic [3:0]       r_prev_ctl, r_prev_serr, r_prev_derr;
    logic [31:0]      r_out_data;
    logic [3:0]       r_out_ctl, r_out_serr, r_out_derr;

    logic [3:0]       w_mark;
    logic [2:0]       w_mark_cnt;
    logic [1:0]       w_mark_pos;
    logic [3:0]       w_off_hot;
    logic             w_any_err, w_single, w_good, w_bad;
    logic [7:0]       w_err_inc, w_err_nxt;
    logic [TMR_W-1:0] w_tmr_nxt;
    logic [3:0]       w_match_inc;
    logic             w_drop, w_enter, w_lock_nxt;
    logic [1:0]       w_off_nxt;
    logic [63:0]      w_cat_data;
    logic [7:0]       w_cat_ctl, w_cat_serr, w_cat_derr;

    for (genvar gi = 0; gi < 4; gi++) begin : g_mark
        assign w_mark[gi] = in_is_ctl[gi] && (in_data[8*gi +: 8] == 8'h3C) && !in_symbol_err[gi];
    end

    always_comb begin
        w_mark_pos = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_mark[i]) w_mark_pos = 2'(i);
        end
    end

    assign w_mark_cnt = {2'b00, w_mark[0]} + {2'b00, w_mark[1]} + {2'b00, w_mark[2]} + {2'b00, w_mark[3]};
    assign w_off_hot  = 4'b0001 << r_offset;
    assign w_any_err  = |(in_symbol_err | in_disparity_err);
    assign w_single   = (w_mark_cnt == 3'd1);
    assign w_good     = w_single && (w_mark_pos == r_offset) && !w_any_err;
    assign w_bad      = (|(w_mark & ~w_off_hot)) || (w_mark_cnt > 3'd1) || w_any_err;

    // Loss decisions use the post-update counter values so lock drops on the offending word.
    assign w_err_inc   = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
    assign w_err_nxt   = w_bad ? w_err_inc : (w_good ? 8'd0 : r_err_cnt);
    assign w_tmr_nxt   = w_good ? '0 : r_timer + TMR_W'(1);
    assign w_drop      = (r_state == ST_LOCKED) && ((w_err_nxt == c_loss_thr) || (w_tmr_nxt == c_timeout));
    assign w_match_inc = r_match_cnt + 4'd1;
    assign w_enter     = ((r_state == ST_HUNT) && w_single && (LOCK_COUNT == 1)) ||
                         ((r_state == ST_VERIFY) && w_good && (w_match_inc == c_lock_cnt));
    assign w_lock_nxt  = w_enter || ((r_state == ST_LOCKED) && !w_drop);
    assign w_off_nxt   = ((r_state == ST_HUNT) && w_single) ? w_mark_pos : r_offset;

    assign w_cat_data = {in_data, r_prev_data};
    assign w_cat_ctl  = {in_is_ctl, r_prev_ctl};
    assign w_cat_serr = {in_symbol_err, r_prev_serr};
    assign w_cat_derr = {in_disparity_err, r_prev_derr};

    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            r_state     <= ST_HUNT;
            r_match_cnt <= 4'd0;
            r_err_cnt   <= 8'd0;
            r_timer     <= '0;
            r_offset    <= 2'd0;
            r_locked    <= 1'b0;
            r_out_valid <= 1'b0;
            r_prev_data <= 32'd0;
            r_prev_ctl  <= 4'd0;
            r_prev_serr <= 4'd0;
            r_prev_derr <= 4'd0;
            r_out_data  <= 32'd0;
            r_out_ctl   <= 4'd0;
            r_out_serr  <= 4'd0;
            r_out_derr  <= 4'd0;
        end else if (in_valid) begin
            r_prev_data <= in_data;
            r_prev_ctl  <= in_is_ctl;
            r_prev_serr <= in_symbol_err;
            r_prev_derr <= in_disparity_err;
            r_offset    <= w_off_nxt;
            r_locked    <= w_lock_nxt;
            r_out_valid <= w_lock_nxt;
            if (w_lock_nxt) begin
                r_out_data <= w_cat_data[{w_off_nxt, 3'b000} +: 32];
                r_out_ctl  <= w_cat_ctl[w_off_nxt +: 4];
                r_out_serr <= w_cat_serr[w_off_nxt +: 4];
                r_out_derr <= w_cat_derr[w_off_nxt +: 4];
            end
            case (r_state)
                ST_HUNT: begin
                    if (w_single) begin
                        r_match_cnt <= 4'd1;
                        r_err_cnt   <= 8'd0;
                        r_timer     <= '0;
                        r_state     <= (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (w_bad) begin
                        r_state <= ST_HUNT;
                    end else if (w_good) begin
                        r_match_cnt <= w_match_inc;
                        if (w_match_inc == c_lock_cnt) begin
                            r_state   <= ST_LOCKED;
                            r_err_cnt <= 8'd0;
                            r_timer   <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_drop) begin
                        r_state   <= ST_HUNT;
                        r_err_cnt <= 8'd0;
                        r_timer   <= '0;
                    end else begin
                        r_err_cnt <= w_err_nxt;
                        r_timer   <= w_tmr_nxt;
                    end
                end
                default: r_state <= ST_HUNT;
            endcase
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid         = r_out_valid;
    assign out_data          = r_out_data;
    assign out_is_ctl        = r_out_ctl;
    assign out_symbol_err    = r_out_serr;
    assign out_disparity_err = r_out_derr;
    assign locked            = r_locked;
    assign offset            = r_offset;

`ifdef QSGMII_ALIGN_STATS_EN
    logic [15:0] r_relock_cnt;
    logic [15:0] r_bad_cnt;
    logic        r_locked_once;

    // The very first lock after reset is acquisition, not a relock.
    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            r_relock_cnt  <= 16'd0;
            r_bad_cnt     <= 16'd0;
            r_locked_once <= 1'b0;
        end else if (in_valid) begin
            if (w_enter) begin
                if (r_locked_once && (r_relock_cnt != 16'hFFFF)) r_relock_cnt <= r_relock_cnt + 16'd1;
                r_locked_once <= 1'b1;
            end
            if ((r_state == ST_LOCKED) && w_bad && (r_bad_cnt != 16'hFFFF)) r_bad_cnt <= r_bad_cnt + 16'd1;
        end
    end

    assign relock_count   = r_relock_cnt;
    assign bad_word_count = r_bad_cnt;
`endif

endmodule
`default_nettype wire
